fc_layer_seq: RTL and testbench

//  Binarised fully-connected layer: out[n] = (popcount(XNOR(act, W[n])) > TH[n]).

---
 rtl/fc_pkg.sv | 43 ++++
 rtl/fc_pe.sv | 44 ++++
 rtl/fc_layer_seq.sv | 163 ++++++++++++++++
 tb/tb_fc_layer_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared state type, widths and reduction helpers for fc_layer_seq.
// FC_LAYER_SEQ_MAJORITY_EN selects the majority-of-3 reduction variant.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OUTPUT
  } state_t;

  // widest reduced slice a lane may popcount in one cycle
  localparam int POP_MAX = 4096;

`ifdef FC_LAYER_SEQ_MAJORITY_EN
  localparam bit MAJ_EN = 1'b1;
`else
  localparam bit MAJ_EN = 1'b0;
`endif

  function automatic int acc_w(input int ch_in);
    return MAJ_EN ? $clog2(ch_in / 3 + 1)
                  : $clog2(ch_in + 1);
  endfunction

  function automatic int popcount(
    input logic [POP_MAX-1:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++)
      n += int'(v[i]);
    return n;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fc_pe.sv
// fc_pe: one output lane - XNOR (or majority) reduce, popcount, accumulate, compare.
// FC_LAYER_SEQ_MAJORITY_EN groups XNOR bits in triples before the popcount.
module fc_pe
  import fc_pkg::*;
#(
  parameter int SIMD  = 256,
  parameter int ACC_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             first,
  input  logic [SIMD-1:0]  act,
  input  logic [SIMD-1:0]  w,
  input  logic [ACC_W-1:0] th,
  output logic             hit
);

  logic [SIMD-1:0]    xn;
  logic [POP_MAX-1:0] red;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;

  // reduce this slice and fold it into the running sum
  always_comb begin
    xn  = ~(act ^ w);
    red = '0;
`ifdef FC_LAYER_SEQ_MAJORITY_EN
    for (int g = 0; g < SIMD / 3; g++)
      red[g] = maj3(xn[3*g], xn[3*g+1], xn[3*g+2]);
`else
    red[SIMD-1:0] = xn;
`endif
    sum = (first ? '0 : acc)
        + ACC_W'(popcount(red));
    hit = sum > th;
  end

  // partial sum carried across SIMD folds
  always_ff @(posedge clk)
    if (reset)   acc <= '0;
    else if (en) acc <= sum;

endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: binarised FC layer walking neuron folds (outer) and SIMD folds (inner).
// FC_LAYER_SEQ_MAJORITY_EN builds the majority-of-3 variant.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter  int CH_IN  = 4096,
  parameter  int CH_OUT = 512,
  parameter  int PE     = 8,
  parameter  int SIMD   = 256,
  localparam int NF     = CH_OUT / PE,
  localparam int SF     = CH_IN / SIMD,
  localparam int ACC_W  = acc_w(CH_IN),
  localparam int AW     = (NF * SF > 1) ? $clog2(NF * SF) : 1,
  localparam int TW     = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_wr_en,
  input  logic [AW-1:0]         w_wr_addr,
  input  logic [PE*SIMD-1:0]    w_wr_data,
  input  logic                  th_wr_en,
  input  logic [TW-1:0]         th_wr_addr,
  input  logic [PE*ACC_W-1:0]   th_wr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH_IN-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_OUT-1:0]     out_data,
  output logic                  busy
);

  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;

  if (CH_OUT % PE != 0) begin : g_bad_pe
    $error("CH_OUT must be a multiple of PE");
  end
  if (CH_IN % SIMD != 0) begin : g_bad_simd
    $error("CH_IN must be a multiple of SIMD");
  end
  if (SIMD > POP_MAX) begin : g_bad_pop
    $error("SIMD exceeds POP_MAX");
  end
  if (MAJ_EN && (CH_IN % 3 != 0 || SIMD % 3 != 0)) begin : g_bad_maj
    $error("majority build needs CH_IN and SIMD divisible by 3");
  end

  state_t state, state_n;

  logic [CH_IN-1:0]   act;
  logic [TW-1:0]      nf, nf2;
  logic [SFW-1:0]     sf, sf2;
  logic               drain;
  logic               accept, issue, fin;
  logic               v2, first2, last2;
  logic [AW-1:0]      rd_addr;
  logic [PE*SIMD-1:0] w_q;
  logic [PE*ACC_W-1:0] th_q;
  logic [SIMD-1:0]    act_slice;
  logic [PE-1:0]      hit;

  logic [PE*SIMD-1:0]  w_mem  [NF*SF];
  logic [PE*ACC_W-1:0] th_mem [NF];

  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == OUTPUT;
  assign accept    = in_valid && in_ready;
  assign issue     = state == COMPUTE && !drain;
  assign rd_addr   = AW'(int'(nf) * SF + int'(sf));
  assign fin       = v2 && last2 && nf2 == TW'(NF - 1);
  assign act_slice = act[int'(sf2)*SIMD +: SIMD];

  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= state_n;

  // next-state: hold unless the phase's event fires
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = COMPUTE;
      COMPUTE: if (fin)       state_n = OUTPUT;
      OUTPUT:  if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // fold counters, sf inner and nf outer; drain waits for the last read
  always_ff @(posedge clk)
    if (reset) begin
      nf    <= '0;
      sf    <= '0;
      drain <= 1'b0;
      act   <= '0;
    end else if (accept) begin
      nf    <= '0;
      sf    <= '0;
      drain <= 1'b0;
      act   <= in_data;
    end else if (issue) begin
      if (sf == SFW'(SF - 1)) begin
        sf <= '0;
        if (nf == TW'(NF - 1)) drain <= 1'b1;
        else                   nf    <= nf + TW'(1);
      end else begin
        sf <= sf + SFW'(1);
      end
    end

  // fold tags aligned with the RAM read data
  always_ff @(posedge clk)
    if (reset) begin
      v2     <= 1'b0;
      nf2    <= '0;
      sf2    <= '0;
      first2 <= 1'b0;
      last2  <= 1'b0;
    end else begin
      v2     <= issue;
      nf2    <= nf;
      sf2    <= sf;
      first2 <= sf == '0;
      last2  <= sf == SFW'(SF - 1);
    end

  // weight and threshold RAMs: writes only while idle, 1-cycle reads
  always_ff @(posedge clk) begin
    if (w_wr_en && in_ready)
      w_mem[w_wr_addr] <= w_wr_data;
    if (th_wr_en && in_ready)
      th_mem[th_wr_addr] <= th_wr_data;
    if (issue) begin
      w_q  <= w_mem[rd_addr];
      th_q <= th_mem[nf];
    end
  end

  for (genvar p = 0; p < PE; p++) begin : g_pe
    fc_pe #(
      .SIMD  (SIMD),
      .ACC_W (ACC_W)
    ) u_pe (
      .clk   (clk),
      .reset (reset),
      .en    (v2),
      .first (first2),
      .act   (act_slice),
      .w     (w_q[p*SIMD +: SIMD]),
      .th    (th_q[p*ACC_W +: ACC_W]),
      .hit   (hit[p])
    );
  end

  // commit lane bits of a finished neuron fold
  always_ff @(posedge clk)
    if (reset)
      out_data <= '0;
    else if (v2 && last2)
      out_data[int'(nf2)*PE +: PE] <= hit;

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: randomized and directed checks of fc_layer_seq against a neuron-level model.
// Define FC_LAYER_SEQ_MAJORITY_EN to exercise the majority-of-3 build.
module tb_fc_layer_seq;

`ifdef FC_LAYER_SEQ_MAJORITY_EN
  localparam int CH_IN = 18;
  localparam int SIMD  = 9;
  localparam int ACC_W = 3;
  localparam int MAXC  = 6;
`else
  localparam int CH_IN = 16;
  localparam int SIMD  = 8;
  localparam int ACC_W = 5;
  localparam int MAXC  = 16;
`endif
  localparam int CH_OUT = 8;
  localparam int PE     = 2;
  localparam int NF     = CH_OUT / PE;
  localparam int SF     = CH_IN / SIMD;
  localparam int ROWS   = NF * SF;
  localparam int AW     = $clog2(ROWS);
  localparam int TW     = $clog2(NF);
  localparam int LAT    = ROWS + 2;
  localparam int WW     = PE * SIMD;
  localparam int THW    = PE * ACC_W;

  logic              clk;
  logic              reset;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic [WW-1:0]     w_wr_data;
  logic              th_wr_en;
  logic [TW-1:0]     th_wr_addr;
  logic [THW-1:0]    th_wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [CH_IN-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_OUT-1:0] out_data;
  logic              busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  logic [WW-1:0]     wm  [ROWS];
  logic [THW-1:0]    thm [NF];
  logic [CH_OUT-1:0] exp_out = '0;

  fc_layer_seq #(
    .CH_IN  (CH_IN),
    .CH_OUT (CH_OUT),
    .PE     (PE),
    .SIMD   (SIMD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_wr_en    (w_wr_en),
    .w_wr_addr  (w_wr_addr),
    .w_wr_data  (w_wr_data),
    .th_wr_en   (th_wr_en),
    .th_wr_addr (th_wr_addr),
    .th_wr_data (th_wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // neuron n = nf*PE+p sees weight bit i at row nf*SF + i/SIMD, lane p
  function automatic logic [CH_OUT-1:0] model(input logic [CH_IN-1:0] a);
    logic [CH_OUT-1:0] r;
    logic [CH_IN-1:0]  x;
    int f, p, cnt, th;
    r = '0;
    for (int n = 0; n < CH_OUT; n++) begin
      f = n / PE;
      p = n % PE;
      for (int i = 0; i < CH_IN; i++)
        x[i] = ~(a[i] ^ wm[f*SF + i/SIMD][p*SIMD + i%SIMD]);
      cnt = 0;
`ifdef FC_LAYER_SEQ_MAJORITY_EN
      for (int k = 0; k < CH_IN / 3; k++)
        if (int'(x[3*k]) + int'(x[3*k+1]) + int'(x[3*k+2]) >= 2)
          cnt++;
`else
      for (int i = 0; i < CH_IN; i++)
        cnt += int'(x[i]);
`endif
      th = int'(thm[f][p*ACC_W +: ACC_W]);
      r[n] = cnt > th;
    end
    return r;
  endfunction

  // every cycle: handshake flags consistent, result matches model when valid
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("ready_vs_busy", in_ready, !busy);
      if (out_valid)
        check("out_data_model", out_data, exp_out);
    end
  end

  task automatic set_mem(input logic [WW-1:0] wv,
                         input int th_even,
                         input int th_odd);
    for (int r = 0; r < ROWS; r++) wm[r] = wv;
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < PE; p++)
        thm[f][p*ACC_W +: ACC_W] =
          ACC_W'(((f*PE + p) % 2 == 0) ? th_even : th_odd);
  endtask

  task automatic rand_mem();
    for (int r = 0; r < ROWS; r++) wm[r] = WW'($urandom);
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < PE; p++)
        thm[f][p*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, MAXC));
  endtask

  task automatic push_mem();
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      w_wr_en   = 1'b1;
      w_wr_addr = AW'(r);
      w_wr_data = wm[r];
    end
    for (int f = 0; f < NF; f++) begin
      @(negedge clk);
      w_wr_en    = 1'b0;
      th_wr_en   = 1'b1;
      th_wr_addr = TW'(f);
      th_wr_data = thm[f];
    end
    @(negedge clk);
    th_wr_en = 1'b0;
  endtask

  // one inference: accept, wait, hold in OUTPUT, release
  task automatic run(input logic [CH_IN-1:0] a,
                     input int hold,
                     input bit intrude,
                     input bit wr_acc);
    int lat;
    int row;
    check("idle_ready", in_ready, 1);
    if (wr_acc) begin
      row = $urandom_range(0, ROWS - 1);
      wm[row]   = WW'($urandom);
      w_wr_en   = 1'b1;
      w_wr_addr = AW'(row);
      w_wr_data = wm[row];
    end
    exp_out  = model(a);
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    w_wr_en  = 1'b0;
    in_valid = 1'b0;
    in_data  = CH_IN'($urandom);
    check("busy_compute", busy, 1);
    lat = 1;
    while (!out_valid && lat < LAT + 20) begin
      if (intrude) begin
        w_wr_en    = 1'b1;
        w_wr_addr  = AW'(lat % ROWS);
        w_wr_data  = '0;
        th_wr_en   = 1'b1;
        th_wr_addr = TW'(lat % NF);
        th_wr_data = '1;
      end
      @(negedge clk);
      lat++;
    end
    w_wr_en  = 1'b0;
    th_wr_en = 1'b0;
    check("latency", lat, LAT);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", out_valid, 1);
      check("hold_not_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = CH_IN'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_idle", busy, 0);
    check("data_held", out_data, exp_out);
  endtask

  task automatic abort();
    in_valid = 1'b1;
    in_data  = '1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check("abort_data", out_data, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_addr  = '0;
    w_wr_data  = '0;
    th_wr_en   = 1'b0;
    th_wr_addr = '0;
    th_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    reset  = 1'b0;
    chk_en = 1'b1;

    set_mem('1, MAXC - 1, MAXC - 1);
    push_mem();
    run('1, 0, 0, 0);
    check("all_ones_lit", out_data, 8'hFF);

    set_mem('1, MAXC, MAXC);
    push_mem();
    run('1, 0, 0, 0);
    check("th_eq_max_lit", out_data, 8'h00);

`ifdef FC_LAYER_SEQ_MAJORITY_EN
    begin : t_maj
      logic [SIMD-1:0] pat;
      pat = 9'b011011011;
      set_mem({PE{pat}}, 5, 6);
      push_mem();
      run('1, 0, 0, 0);
      check("maj_th56_lit", out_data, 8'h55);
      set_mem({PE{pat}}, 6, 6);
      push_mem();
      run('1, 0, 0, 0);
      check("maj_th6_lit", out_data, 8'h00);
    end
`else
    set_mem('1, 0, 0);
    push_mem();
    run('0, 0, 0, 0);
    check("act0_lit", out_data, 8'h00);
    set_mem('1, 7, 8);
    push_mem();
    run(16'h00FF, 0, 0, 0);
    check("act00ff_lit", out_data, 8'h55);
`endif

    rand_mem();
    push_mem();
    run(CH_IN'($urandom), 5, 0, 0);

    set_mem('1, MAXC - 1, MAXC - 1);
    push_mem();
    abort();
    run('1, 0, 0, 0);
    check("rerun_lit", out_data, 8'hFF);

    run('1, 0, 1, 0);
    check("intrude_lit", out_data, 8'hFF);
    run('1, 0, 0, 0);
    check("intrude_kept_lit", out_data, 8'hFF);

    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) begin
        rand_mem();
        push_mem();
      end
      run(CH_IN'($urandom), $urandom_range(0, 3),
          1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
